vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from a single 25 MHz pixel clock. Drives the DrawX/DrawY/blank interface consumed by sprite and background renderers, plus hs/vs to the DAC connector. Sync and blank outputs are delayed by a configurable number of cycles so they stay aligned with renderer colour outputs that pass through ROM and register stages.

---
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// VgaTimingGen (module vga_timing_gen)
//
// Produces 640x480@60 Hz VGA raster timing from a single 25 MHz pixel clock.
// A horizontal/vertical counter pair is exposed directly as DrawX/DrawY for
// the renderers. blank/hs/vs are decoded from the counters and then delayed
// by PIPE_DELAY cycles so they line up with colour data that the renderers
// push through ROM and register stages.
//
// Ports:
//   vga_clk      in   1  pixel clock, all state changes on its rising edge
//   Reset        in   1  synchronous active-high reset
//   DrawX        out 10  horizontal counter, 0..H_TOTAL-1 (undelayed)
//   DrawY        out 10  vertical counter, 0..V_TOTAL-1 (undelayed)
//   blank        out  1  1 = visible pixel, delayed by PIPE_DELAY
//   hs           out  1  horizontal sync, active-low, delayed by PIPE_DELAY
//   vs           out  1  vertical sync, active-low, delayed by PIPE_DELAY
//   sync         out  1  composite sync to the DAC, tied to 0
//   line_start   out  1  high while DrawX == 0 (undelayed)
//   frame_start  out  1  high while DrawX == 0 and DrawY == 0 (undelayed)
//   frame_count  out  8  completed-frame counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       Reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       sync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Delay-line word is {vis, hsN, vsN}; the idle value has both syncs
    // deasserted (high) and the pixel blanked.
    localparam logic [2:0] STAGE_INACTIVE = 3'b011;

    logic [9:0] hCount_q, hCount_d;
    logic [9:0] vCount_q, vCount_d;
    logic [7:0] frameCount_q, frameCount_d;
    logic [2:0] rawDecode;
    logic [2:0] pipeOut;

    // Next-state for the raster counters. The vertical counter only moves
    // when the line ends, and the frame counter only moves when the last
    // pixel of the last line rolls back to the origin.
    always_comb begin
        hCount_d     = hCount_q + 10'd1;
        vCount_d     = vCount_q;
        frameCount_d = frameCount_q;
        if (hCount_q == H_LAST) begin
            hCount_d = '0;
            if (vCount_q == V_LAST) begin
                vCount_d     = '0;
                frameCount_d = frameCount_q + 8'd1;
            end else begin
                vCount_d = vCount_q + 10'd1;
            end
        end
    end

    // Counter registers with synchronous reset to the raster origin.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            hCount_q     <= '0;
            vCount_q     <= '0;
            frameCount_q <= '0;
        end else begin
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            frameCount_q <= frameCount_d;
        end
    end

    // Undelayed decode of the current raster position. vs depends only on
    // the line number, so it changes on the same edge the line wraps.
    always_comb begin
        rawDecode    = STAGE_INACTIVE;
        rawDecode[2] = (hCount_q < H_VIS_END) && (vCount_q < V_VIS_END);
        rawDecode[1] = !((hCount_q >= H_SYNC_START) && (hCount_q < H_SYNC_END));
        rawDecode[0] = !((vCount_q >= V_SYNC_START) && (vCount_q < V_SYNC_END));
    end

    // Alignment delay for blank/hs/vs. Reset flushes every stage to the
    // idle value so a sync pulse in flight is cut off rather than stretched.
    generate
        if (PIPE_DELAY == 0) begin : gNoDelay
            assign pipeOut = rawDecode;
        end else begin : gDelay
            logic [2:0] stage_q [PIPE_DELAY];

            always_ff @(posedge vga_clk) begin
                if (Reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stage_q[i] <= STAGE_INACTIVE;
                    end
                end else begin
                    stage_q[0] <= rawDecode;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign pipeOut = stage_q[PIPE_DELAY-1];
        end
    endgenerate

    assign DrawX       = hCount_q;
    assign DrawY       = vCount_q;
    assign blank       = pipeOut[2];
    assign hs          = pipeOut[1];
    assign vs          = pipeOut[0];
    assign sync        = 1'b0;
    assign line_start  = (hCount_q == 10'd0);
    assign frame_start = (hCount_q == 10'd0) && (vCount_q == 10'd0);
    assign frame_count = frameCount_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// TbVgaTimingGen (module tb_vga_timing_gen)
//
// Three timing generators run side by side from one pixel clock:
//   A: default 640x480 timing, PIPE_DELAY=2 (line timing, reset values)
//   B: shrunken 15x10 raster, PIPE_DELAY=2 (vertical sync, frame wrap,
//      256-frame counter wrap, mid-frame reset)
//   C: default timing, PIPE_DELAY=0 (combinational decode path)
// A raster model derives every output from the number of cycles since the
// last reset using plain division/modulo and is compared each cycle; a
// directed table of hand-computed values pins the model itself.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int hv; int hf; int hsw; int hb;
        int vv; int vf; int vsw; int vb;
        int d;
    } timing_t;

    typedef struct {
        int x; int y; int blank; int hs; int vs;
        int ls; int fs; int fc;
    } expect_t;

    typedef struct {
        int cyc;
        int sig;
        int val;
        string name;
    } directed_t;

    localparam timing_t TIM_A = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    localparam timing_t TIM_B = '{8, 2, 3, 2, 6, 1, 2, 1, 2};
    localparam timing_t TIM_C = '{640, 16, 96, 48, 480, 10, 2, 33, 0};

    logic clk = 1'b0;
    logic rstMain;
    logic rstB;

    logic [9:0] aDrawX, aDrawY, bDrawX, bDrawY, cDrawX, cDrawY;
    logic aBlank, aHs, aVs, aSync, aLs, aFs;
    logic bBlank, bHs, bVs, bSync, bLs, bFs;
    logic cBlank, cHs, cVs, cSync, cLs, cFs;
    logic [7:0] aFc, bFc, cFc;

    int checks = 0;
    int failures = 0;
    int tMain = 0;
    int tB = 0;
    bit validMain = 1'b0;
    bit validB = 1'b0;

    // 25 MHz pixel clock.
    always #20 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .PIPE_DELAY(2)
    ) uA (
        .vga_clk(clk), .Reset(rstMain), .DrawX(aDrawX), .DrawY(aDrawY),
        .blank(aBlank), .hs(aHs), .vs(aVs), .sync(aSync),
        .line_start(aLs), .frame_start(aFs), .frame_count(aFc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIPE_DELAY(2)
    ) uB (
        .vga_clk(clk), .Reset(rstB), .DrawX(bDrawX), .DrawY(bDrawY),
        .blank(bBlank), .hs(bHs), .vs(bVs), .sync(bSync),
        .line_start(bLs), .frame_start(bFs), .frame_count(bFc)
    );

    vga_timing_gen #(
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .PIPE_DELAY(0)
    ) uC (
        .vga_clk(clk), .Reset(rstMain), .DrawX(cDrawX), .DrawY(cDrawY),
        .blank(cBlank), .hs(cHs), .vs(cVs), .sync(cSync),
        .line_start(cLs), .frame_start(cFs), .frame_count(cFc)
    );

    // Raster model: everything follows from the cycle count t since the last
    // reset edge. Position is t mod line/frame length; the delayed signals
    // are the decode of position t-d, or idle while t < d.
    function automatic expect_t modelAt(input timing_t tm, input int t);
        expect_t e;
        int ht, vt, td, px, py;
        ht = tm.hv + tm.hf + tm.hsw + tm.hb;
        vt = tm.vv + tm.vf + tm.vsw + tm.vb;
        e.x  = t % ht;
        e.y  = (t / ht) % vt;
        e.fc = (t / (ht * vt)) % 256;
        e.ls = (e.x == 0) ? 1 : 0;
        e.fs = (e.x == 0 && e.y == 0) ? 1 : 0;
        if (t < tm.d) begin
            e.blank = 0;
            e.hs    = 1;
            e.vs    = 1;
        end else begin
            td = t - tm.d;
            px = td % ht;
            py = (td / ht) % vt;
            e.blank = (px < tm.hv && py < tm.vv) ? 1 : 0;
            e.hs = (px >= tm.hv + tm.hf && px < tm.hv + tm.hf + tm.hsw) ? 0 : 1;
            e.vs = (py >= tm.vv + tm.vf && py < tm.vv + tm.vf + tm.vsw) ? 0 : 1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0d)", name, actual, expected, tMain);
        end
    endtask

    task automatic applyStimulus(input logic mainReset, input logic bReset);
        rstMain = mainReset;
        rstB    = bReset;
    endtask

    task automatic compareAll(input string tag, input expect_t e,
                              input int x, input int y, input int bl, input int h,
                              input int v, input int s, input int ls, input int fs,
                              input int fc);
        checkOutput({tag, ".DrawX"}, x, e.x);
        checkOutput({tag, ".DrawY"}, y, e.y);
        checkOutput({tag, ".blank"}, bl, e.blank);
        checkOutput({tag, ".hs"}, h, e.hs);
        checkOutput({tag, ".vs"}, v, e.vs);
        checkOutput({tag, ".sync"}, s, 0);
        checkOutput({tag, ".line_start"}, ls, e.ls);
        checkOutput({tag, ".frame_start"}, fs, e.fs);
        checkOutput({tag, ".frame_count"}, fc, e.fc);
    endtask

    // Cycle bookkeeping for the model: a sampled reset puts the raster back
    // at t=0, otherwise time advances by one pixel.
    always @(posedge clk) begin
        if (rstMain) begin
            tMain     <= 0;
            validMain <= 1'b1;
        end else begin
            tMain <= tMain + 1;
        end
        if (rstB) begin
            tB     <= 0;
            validB <= 1'b1;
        end else begin
            tB <= tB + 1;
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (validMain) begin
            compareAll("A", modelAt(TIM_A, tMain), int'(aDrawX), int'(aDrawY), int'(aBlank),
                       int'(aHs), int'(aVs), int'(aSync), int'(aLs), int'(aFs), int'(aFc));
            compareAll("C", modelAt(TIM_C, tMain), int'(cDrawX), int'(cDrawY), int'(cBlank),
                       int'(cHs), int'(cVs), int'(cSync), int'(cLs), int'(cFs), int'(cFc));
        end
        if (validB) begin
            compareAll("B", modelAt(TIM_B, tB), int'(bDrawX), int'(bDrawY), int'(bBlank),
                       int'(bHs), int'(bVs), int'(bSync), int'(bLs), int'(bFs), int'(bFc));
        end
    end

    function automatic int sampleSignal(input int code);
        case (code)
            0:  return int'(aBlank);
            1:  return int'(aHs);
            2:  return int'(aLs);
            3:  return int'(aDrawX);
            4:  return int'(aDrawY);
            5:  return int'(cBlank);
            6:  return int'(cHs);
            7:  return int'(bVs);
            8:  return int'(bFc);
            9:  return int'(bDrawX);
            10: return int'(bDrawY);
            11: return int'(bFs);
            default: return -1;
        endcase
    endfunction

    // Waits on negedges until the shared cycle count reaches n, bounded.
    task automatic waitCycle(input int n);
        int guard;
        guard = 0;
        while (tMain != n && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        if (tMain != n) checkOutput("waitCycle", tMain, n);
    endtask

    // Hand-computed expectations, in increasing cycle order. Cycle 0 is the
    // first cycle after reset release; A and B share that origin here.
    directed_t directed [] = '{
        '{0,     5,  1,   "C.blank@origin"},
        '{1,     0,  0,   "A.blank@1"},
        '{2,     0,  1,   "A.blank@2"},
        '{106,   7,  1,   "B.vs@106"},
        '{107,   7,  0,   "B.vs@107"},
        '{136,   7,  0,   "B.vs@136"},
        '{137,   7,  1,   "B.vs@137"},
        '{150,   8,  1,   "B.frame_count@150"},
        '{150,   9,  0,   "B.DrawX@150"},
        '{150,   10, 0,   "B.DrawY@150"},
        '{150,   11, 1,   "B.frame_start@150"},
        '{641,   0,  1,   "A.blank@641"},
        '{642,   0,  0,   "A.blank@642"},
        '{655,   6,  1,   "C.hs@655"},
        '{656,   6,  0,   "C.hs@656"},
        '{657,   1,  1,   "A.hs@657"},
        '{658,   1,  0,   "A.hs@658"},
        '{751,   6,  0,   "C.hs@751"},
        '{752,   6,  1,   "C.hs@752"},
        '{753,   1,  0,   "A.hs@753"},
        '{754,   1,  1,   "A.hs@754"},
        '{799,   2,  0,   "A.line_start@799"},
        '{800,   2,  1,   "A.line_start@800"},
        '{800,   3,  0,   "A.DrawX@800"},
        '{800,   4,  1,   "A.DrawY@800"},
        '{1600,  2,  1,   "A.line_start@1600"},
        '{1600,  4,  2,   "A.DrawY@1600"},
        '{38250, 8,  255, "B.frame_count@255frames"},
        '{38400, 8,  0,   "B.frame_count@256frames"},
        '{38400, 11, 1,   "B.frame_start@256frames"}
    };

    // Directed sequence: reset, timed spot checks, then a mid-frame reset on
    // B while its vertical sync is active.
    initial begin
        int guard;
        applyStimulus(1'b1, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("A.reset.DrawX", int'(aDrawX), 0);
        checkOutput("A.reset.DrawY", int'(aDrawY), 0);
        checkOutput("A.reset.blank", int'(aBlank), 0);
        checkOutput("A.reset.hs", int'(aHs), 1);
        checkOutput("A.reset.vs", int'(aVs), 1);
        checkOutput("A.reset.frame_count", int'(aFc), 0);
        checkOutput("A.reset.frame_start", int'(aFs), 1);
        applyStimulus(1'b0, 1'b0);

        foreach (directed[i]) begin
            waitCycle(directed[i].cyc);
            checkOutput(directed[i].name, sampleSignal(directed[i].sig), directed[i].val);
        end

        guard = 0;
        while (!(bDrawY == 10'd7 && bDrawX == 10'd12) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("B.midframe.reached", (bDrawY == 10'd7 && bDrawX == 10'd12) ? 1 : 0, 1);
        checkOutput("B.midframe.vsActive", int'(bVs), 0);
        checkOutput("B.midframe.hsActive", int'(bHs), 0);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("B.midframe.DrawX", int'(bDrawX), 0);
        checkOutput("B.midframe.DrawY", int'(bDrawY), 0);
        checkOutput("B.midframe.vs", int'(bVs), 1);
        checkOutput("B.midframe.hs", int'(bHs), 1);
        checkOutput("B.midframe.blank", int'(bBlank), 0);
        checkOutput("B.midframe.frame_count", int'(bFc), 0);
        applyStimulus(1'b0, 1'b0);

        repeat (400) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
